uart_tx_frame: RTL and testbench

UART transmit framer. It is the transmit-side counterpart of the receive path's deserializer and parity checker. It accepts one parallel word per handshake and serializes it onto a single line as: start bit, DATAWIDTH data bits LSB first, optional parity bit, stop bit. Parity convention matches the receiver: parityType=0 even, parityType=1 odd. The block sits between the host-side TX interface and the UART TX pin.

---
 rtl/uart_tx_frame.sv | 104 ++++++++++
 tb/tb_uart_tx_frame.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer sending start, LSB-first data, optional parity and stop bits.
// Define UART_TX_TWO_STOP_EN to send two stop bits instead of one.
module uart_tx_frame #(
  parameter int DATAWIDTH    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] dataIn,
  input  logic                 dataValid,
  input  logic                 parityEn,
  input  logic                 parityType,
  output logic                 txOut,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATAWIDTH) + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATAWIDTH-1:0] shift_q, shift_d;
  logic                 par_q, par_d, pen_q, pen_d;
  logic                 tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic                 wrap, last_stop;
  assign wrap  = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign txOut = tx_q;
  assign busy  = busy_q;
  assign done  = done_q;
`ifdef UART_TX_TWO_STOP_EN
  logic stop_q, stop_d;
  assign stop_d    = (state_q == STOP && wrap) ? ~stop_q : stop_q;
  assign last_stop = stop_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) stop_q <= 1'b0;
    else      stop_q <= stop_d;
`else
  assign last_stop = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pen_d   = pen_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (dataValid) begin
        state_d = START;
        cnt_d   = '0;
        bit_d   = '0;
        shift_d = dataIn;
        par_d   = parityType ? ~^dataIn : ^dataIn;
        pen_d   = parityEn;
        busy_d  = 1'b1;
      end
    end else begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (wrap) begin
        case (state_q)
          START:  state_d = DATA;
          DATA: begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BW'(DATAWIDTH - 1)) state_d = pen_q ? PARITY : STOP;
          end
          PARITY: state_d = STOP;
          default: if (last_stop) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        endcase
      end
    end
    // line level is registered from the next state so the pin never glitches
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_d : 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      pen_q   <= pen_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: scoreboard bench; stimulus queues hand-computed frames, a monitor checks the serial line.
module tb_uart_tx_frame;
  localparam int C = 4;
  logic       clk = 0, rst = 0, dataValid = 0, parityEn = 0, parityType = 0;
  logic [7:0] dataIn = '0;
  logic       txOut, busy, done;
  int         checks = 0, errors = 0, cyc = 0, start_cyc = 0;
  typedef struct { logic [0:10] seq; int n; } frame_t;
  frame_t     exp_q[$];
  frame_t     mon_f;
  logic       mon_ok, mon_ab;

  uart_tx_frame #(.DATAWIDTH(8), .CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst(rst), .dataIn(dataIn), .dataValid(dataValid),
    .parityEn(parityEn), .parityType(parityType),
    .txOut(txOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // frame bits in transmission order: seq[0] is the start bit
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [0:10] seq, input int n);
    frame_t f;
    f.seq = seq;
    f.n   = n;
    exp_q.push_back(f);
    @(negedge clk);
    dataIn = d; parityEn = pe; parityType = pt; dataValid = 1;
    @(negedge clk);
    dataValid = 0; dataIn = ~d; parityEn = ~pe; parityType = ~pt;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 200 && at < 0; i++) begin
      @(negedge clk);
      if (done) at = cyc;
    end
    chk("done_seen", 32'(at >= 0), 1);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst && busy) begin
      start_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 1, 0);
        while (busy) @(negedge clk);
      end else begin
        mon_f  = exp_q.pop_front();
        mon_ok = 1;
        mon_ab = 0;
        for (int k = 0; k <= mon_f.n * C; k++) begin
          if (k > 0) @(negedge clk);
          if (!rst) begin
            mon_ab = 1;
            break;
          end
          if (k % C == C / 2 && k / C < mon_f.n)
            chk($sformatf("bit%0d", k / C), 32'(txOut), 32'(mon_f.seq[k / C]));
          if (k < mon_f.n * C) mon_ok &= busy & ~done;
          else                 mon_ok &= ~busy & done;
        end
        if (!mon_ab) chk("busy_done_window", 32'(mon_ok), 1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t, d1, bad;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(txOut), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (!txOut || busy || done) bad++;
    end
    chk("idle_deviations", bad, 0);
    send(8'hA5, 1, 0, 11'b01010010101, 11); wait_done(t);
    send(8'h00, 1, 1, 11'b00000000011, 11); wait_done(t);
    send(8'hFF, 1, 1, 11'b01111111111, 11); wait_done(t);
    send(8'h01, 1, 0, 11'b01000000011, 11); wait_done(t);
    send(8'h3C, 0, 0, 11'b00011110011, 10);
    repeat (10) @(negedge clk);
    dataIn = 8'hFF; dataValid = 1;
    @(negedge clk);
    dataValid = 0;
    wait_done(t);
    begin
      frame_t f;
      f.seq = 11'b01010101001; f.n = 11; exp_q.push_back(f);
      f.seq = 11'b00101010101; f.n = 11; exp_q.push_back(f);
    end
    @(negedge clk);
    dataIn = 8'h55; parityEn = 1; parityType = 0; dataValid = 1;
    @(negedge clk);
    dataIn = 8'hAA;
    wait_done(d1);
    @(negedge clk);
    dataValid = 0;
    #1;
    chk("b2b_gap", start_cyc - d1, 1);
    wait_done(t);
    send(8'h07, 0, 0, 11'b01110000011, 10);
    repeat (17) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("rst_mid_tx", 32'(txOut), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || !txOut) bad++;
    end
    chk("rst_hold", bad, 0);
    rst = 1;
    send(8'h81, 1, 1, 11'b01000000111, 11); wait_done(t);
    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
